hex_display_scanner: RTL and testbench

- Time-multiplexes one hexdigit decoder across NUM_DIGITS common-anode seven-segment digits, scanning one digit per refresh slot.
- Holds a shadow copy of the displayed value. The shadow updates only at frame boundaries, through a req/ack handshake, so a frame never shows a torn value.
- Sits between the etch-a-sketch position/status logic and the board display pins.
- Segment and digit-enable outputs are active-low.

---
 rtl/hex_disp_pkg.sv | 30 +++
 rtl/hex_display_scanner_hexdigit.sv | 32 +++
 rtl/hex_display_scanner.sv | 116 +++++++++++
 tb/tb_hex_display_scanner.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/hex_disp_pkg.sv
// Shared constants and the leading-zero visibility helper for the
// multiplexed seven-segment display scanner.
package hex_disp_pkg;

   localparam logic [6:0] SEG_BLANK  = 7'h7F;
   localparam int         NIBBLE_W   = 4;
   localparam int         MAX_DIGITS = 8;
   localparam int         LZ_W       = MAX_DIGITS * NIBBLE_W;

   // Bit k is 1 when digit k survives leading-zero suppression. Digit 0 is
   // always kept so a zero value still shows a single "0".
   function automatic logic [MAX_DIGITS-1:0] lz_visible(
      input logic [LZ_W-1:0] value,
      input int              num_digits,
      input logic            lz_suppress
   );
      logic [MAX_DIGITS-1:0] vis;
      logic                  seen_nonzero;
      vis          = '0;
      seen_nonzero = 1'b0;
      for (int k = MAX_DIGITS - 1; k >= 0; k--) begin
         if (k < num_digits) begin
            seen_nonzero = seen_nonzero | (value[k*NIBBLE_W +: NIBBLE_W] != 4'h0);
            vis[k]       = !lz_suppress || seen_nonzero || (k == 0);
         end
      end
      return vis;
   endfunction

endpackage

// File: rtl/hex_display_scanner_hexdigit.sv
// Hex nibble to active-low seven-segment pattern, bit order {g,f,e,d,c,b,a}.
module hex_display_scanner_hexdigit
   import hex_disp_pkg::*;
(
   input  logic [NIBBLE_W-1:0] nibble,
   output logic [6:0]          seg_n
);

   always_comb begin
      seg_n = SEG_BLANK;
      case (nibble)
         4'h0: seg_n = 7'h40;
         4'h1: seg_n = 7'h79;
         4'h2: seg_n = 7'h24;
         4'h3: seg_n = 7'h30;
         4'h4: seg_n = 7'h19;
         4'h5: seg_n = 7'h12;
         4'h6: seg_n = 7'h02;
         4'h7: seg_n = 7'h78;
         4'h8: seg_n = 7'h00;
         4'h9: seg_n = 7'h10;
         4'hA: seg_n = 7'h08;
         4'hB: seg_n = 7'h03;
         4'hC: seg_n = 7'h46;
         4'hD: seg_n = 7'h21;
         4'hE: seg_n = 7'h06;
         4'hF: seg_n = 7'h0E;
         default: seg_n = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/hex_display_scanner.sv
// Scans NUM_DIGITS common-anode digits from a shadow register that only
// reloads at frame boundaries, so a frame never shows a torn value.
module hex_display_scanner
   import hex_disp_pkg::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 50000,
   parameter int BLANK_CYCLES = 64
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [NIBBLE_W*NUM_DIGITS-1:0] value_in,
   input  logic                           load_req,
   output logic                           load_ack,
   input  logic [NUM_DIGITS-1:0]          blank_mask,
   input  logic                           lz_suppress,
   output logic [6:0]                     seg_n,
   output logic [NUM_DIGITS-1:0]          digit_n,
   output logic                           frame_done
);

   localparam int PRE_W = $clog2(REFRESH_DIV);
   localparam int IDX_W = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;
   localparam int VAL_W = NIBBLE_W * NUM_DIGITS;

   logic [PRE_W-1:0]      pre_q, pre_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [VAL_W-1:0]      shadow_q, shadow_d;
   logic [6:0]            seg_n_q, seg_n_d;
   logic [NUM_DIGITS-1:0] digit_n_q, digit_n_d;
   logic                  load_ack_q, load_ack_d;
   logic                  frame_done_q, frame_done_d;

   logic                  pre_wrap;
   logic                  idx_last;
   logic                  frame_boundary;
   logic                  in_blank;
   logic                  digit_visible;
   logic [MAX_DIGITS-1:0] lz_vis;
   logic [NIBBLE_W-1:0]   cur_nibble;
   logic [6:0]            dec_seg_n;

   assign pre_wrap       = (pre_q == PRE_W'(REFRESH_DIV - 1));
   assign idx_last       = (idx_q == IDX_W'(NUM_DIGITS - 1));
   assign frame_boundary = pre_wrap && idx_last;

   // A zero-length blanking window must not produce an always-false compare.
   generate
      if (BLANK_CYCLES > 0) begin : g_blank
         assign in_blank = (pre_q < PRE_W'(BLANK_CYCLES));
      end else begin : g_no_blank
         assign in_blank = 1'b0;
      end
   endgenerate

   assign lz_vis        = lz_visible(LZ_W'(shadow_q), NUM_DIGITS, lz_suppress);
   assign digit_visible = lz_vis[idx_q] && !blank_mask[idx_q];
   assign cur_nibble    = shadow_q[int'(idx_q)*NIBBLE_W +: NIBBLE_W];

   hex_display_scanner_hexdigit u_hexdigit (
      .nibble (cur_nibble),
      .seg_n  (dec_seg_n)
   );

   always_comb begin
      pre_d = pre_q + PRE_W'(1);
      idx_d = idx_q;
      if (pre_wrap) begin
         pre_d = '0;
         idx_d = idx_last ? '0 : idx_q + IDX_W'(1);
      end
   end

   // Shadow capture and its ack share one edge, so the ack cycle already
   // drives the new value into the scan.
   always_comb begin
      frame_done_d = frame_boundary;
      load_ack_d   = frame_boundary && load_req;
      shadow_d     = load_ack_d ? value_in : shadow_q;
   end

   always_comb begin
      seg_n_d   = SEG_BLANK;
      digit_n_d = '1;
      if (!in_blank && digit_visible) begin
         digit_n_d = ~(NUM_DIGITS'(1) << idx_q);
         seg_n_d   = dec_seg_n;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pre_q        <= '0;
         idx_q        <= '0;
         shadow_q     <= '0;
         seg_n_q      <= SEG_BLANK;
         digit_n_q    <= '1;
         load_ack_q   <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         pre_q        <= pre_d;
         idx_q        <= idx_d;
         shadow_q     <= shadow_d;
         seg_n_q      <= seg_n_d;
         digit_n_q    <= digit_n_d;
         load_ack_q   <= load_ack_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign seg_n      = seg_n_q;
   assign digit_n    = digit_n_q;
   assign load_ack   = load_ack_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Randomized scoreboard bench for hex_display_scanner with a cycle-count
// based reference model of the scan, shadow and handshake.
module tb_hex_display_scanner;

   localparam int ND = 4;
   localparam int RD = 4;
   localparam int BC = 1;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [15:0]   value_in = '0;
   logic          load_req = 1'b0;
   logic          load_ack;
   logic [ND-1:0] blank_mask = '0;
   logic          lz_suppress = 1'b0;
   logic [6:0]    seg_n;
   logic [ND-1:0] digit_n;
   logic          frame_done;

   always #5 clk = ~clk;

   hex_display_scanner #(
      .NUM_DIGITS   (ND),
      .REFRESH_DIV  (RD),
      .BLANK_CYCLES (BC)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .value_in    (value_in),
      .load_req    (load_req),
      .load_ack    (load_ack),
      .blank_mask  (blank_mask),
      .lz_suppress (lz_suppress),
      .seg_n       (seg_n),
      .digit_n     (digit_n),
      .frame_done  (frame_done)
   );

   typedef struct {
      logic [6:0]    seg;
      logic [ND-1:0] dig;
      logic          ack;
      logic          fd;
   } exp_t;

   exp_t exp_q[$];

   logic [6:0] dec_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   // Reference model state: cycles since reset release and the displayed value.
   int            t = 0;
   logic [15:0]   sh = '0;
   logic          req_active = 1'b0;
   logic [15:0]   req_val = '0;
   logic [ND-1:0] nxt_mask = '0;
   logic          nxt_lz = 1'b0;
   int            n_ack = 0;

   int total = 0;
   int passed = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got === want) passed++;
      else $display("FAIL %s at %0t: got %h expected %h", name, $time, got, want);
   endtask

   task automatic step(input logic rst);
      exp_t e;
      int   pre, idx;
      logic vis;
      @(negedge clk);
      reset       = rst;
      load_req    = req_active;
      value_in    = req_active ? req_val : 16'($urandom);
      blank_mask  = nxt_mask;
      lz_suppress = nxt_lz;
      e.seg = 7'h7F; e.dig = '1; e.ack = 1'b0; e.fd = 1'b0;
      if (rst) begin
         t  = 0;
         sh = '0;
      end else begin
         pre  = t % RD;
         idx  = (t / RD) % ND;
         e.fd  = (pre == RD - 1) && (idx == ND - 1);
         e.ack = e.fd && req_active;
         vis = !blank_mask[idx] && !(lz_suppress && idx != 0 && (sh >> (4 * idx)) == 16'h0);
         if (pre >= BC && vis) begin
            e.dig = ~(ND'(1) << idx);
            e.seg = dec_tbl[(sh >> (4 * idx)) & 16'hF];
         end
         if (e.ack) begin
            sh = req_val;
            req_active = 1'b0;
            n_ack++;
         end
         t++;
      end
      exp_q.push_back(e);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step(1'b0);
   endtask

   task automatic load(input logic [15:0] v);
      int guard;
      req_active = 1'b1;
      req_val    = v;
      guard      = 0;
      while (req_active && guard < 100) begin
         step(1'b0);
         guard++;
      end
      if (req_active) begin
         $display("FAIL load_timeout: ack never due for %h", v);
         total++;
         req_active = 1'b0;
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("seg_n", 32'(seg_n), 32'(e.seg));
            chk("digit_n", 32'(digit_n), 32'(e.dig));
            chk("load_ack", 32'(load_ack), 32'(e.ack));
            chk("frame_done", 32'(frame_done), 32'(e.fd));
         end
      end
   end

   initial begin : stimulus
      int guard;
      repeat (3) step(1'b1);

      // Power-up scan of an all-zero shadow.
      run(40);

      load(16'h1A3F);
      run(36);

      // Short request away from the boundary must be ignored.
      guard = 0;
      while (t % 16 != 3 && guard < 40) begin step(1'b0); guard++; end
      req_active = 1'b1; req_val = 16'hBEEF;
      step(1'b0); step(1'b0);
      req_active = 1'b0;
      run(36);

      nxt_lz = 1'b1;
      load(16'h0070);
      run(36);
      load(16'h0000);
      run(36);

      nxt_lz = 1'b0; nxt_mask = 4'b0100;
      load(16'h8888);
      run(36);
      nxt_mask = '0;

      // Reset landing in slot 2 with a request outstanding.
      guard = 0;
      while (!((t / RD) % ND == 2 && t % RD == 2) && guard < 40) begin step(1'b0); guard++; end
      req_active = 1'b1; req_val = 16'h5555;
      step(1'b1); step(1'b1);
      req_active = 1'b0;
      run(36);

      for (int i = 0; i < 2500; i++) begin
         if ($urandom % 64 == 0) begin
            nxt_mask = ND'($urandom);
            nxt_lz   = 1'($urandom);
         end
         if (!req_active && $urandom % 8 == 0) begin
            req_active = 1'b1;
            req_val    = ($urandom % 3 == 0) ? 16'($urandom % 256) : 16'($urandom);
         end else if (req_active && $urandom % 50 == 0) begin
            req_active = 1'b0;
         end
         step($urandom % 300 == 0);
      end
      req_active = 1'b0;
      run(4);

      repeat (2) @(posedge clk);
      #2;
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      if (n_ack == 0) begin
         $display("FAIL ack_count: got 0 expected nonzero");
         total++;
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
